// File: rtl/adder_result_checker_if.sv
// Stimulus/response bundle between the adder test driver and the result checker:
// run control, the operands fed to the adder and the adder's sum/carry outputs.
interface adder_result_checker_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start,
        output in_valid,
        output a,
        output b,
        output cin,
        output sum,
        output cout
    );

    modport slave (
        input start,
        input in_valid,
        input a,
        input b,
        input cin,
        input sum,
        input cout
    );
endinterface

// File: rtl/adder_result_checker.sv
// Checks adder sum/cout against a reference sum over a run of N_VECTORS samples,
// counting vectors and mismatches and capturing the first failing vector.
module adder_result_checker #(
    parameter int  WIDTH     = 8,
    parameter int  N_VECTORS = 65536,
    parameter int  ERR_W     = 16,
    localparam int CNT_W     = 2 * WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_result_checker_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     vec_count,
    output logic [ERR_W-1:0]     err_count,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b,
    output logic                 fail_cin,
    output logic [WIDTH-1:0]     fail_sum,
    output logic                 fail_cout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] VEC_LAST = CNT_W'(N_VECTORS);
    localparam logic [ERR_W-1:0] ERR_SAT  = {ERR_W{1'b1}};

    // Full-precision reference: carry-out lands in the extra top bit.
    function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic             ci);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] vec_count_q, vec_count_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             first_fail_q, first_fail_d;
    logic [WIDTH-1:0] fail_a_q, fail_a_d;
    logic [WIDTH-1:0] fail_b_q, fail_b_d;
    logic             fail_cin_q, fail_cin_d;
    logic [WIDTH-1:0] fail_sum_q, fail_sum_d;
    logic             fail_cout_q, fail_cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             mismatch_s;

    assign mismatch_s = ({bus.cout, bus.sum} != ref_sum(bus.a, bus.b, bus.cin));

    // Next-state, counters and first-failure capture.
    always_comb begin
        state_d      = state_q;
        vec_count_d  = vec_count_q;
        err_count_d  = err_count_q;
        first_fail_d = first_fail_q;
        fail_a_d     = fail_a_q;
        fail_b_d     = fail_b_q;
        fail_cin_d   = fail_cin_q;
        fail_sum_d   = fail_sum_q;
        fail_cout_d  = fail_cout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // start outranks in_valid; the start-cycle sample is dropped
                if (bus.start) begin
                    state_d      = ST_RUN;
                    vec_count_d  = {CNT_W{1'b0}};
                    err_count_d  = {ERR_W{1'b0}};
                    first_fail_d = 1'b0;
                    fail_a_d     = {WIDTH{1'b0}};
                    fail_b_d     = {WIDTH{1'b0}};
                    fail_cin_d   = 1'b0;
                    fail_sum_d   = {WIDTH{1'b0}};
                    fail_cout_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (bus.in_valid) begin
                    vec_count_d = vec_count_q + CNT_W'(1);
                    if (mismatch_s) begin
                        if (err_count_q != ERR_SAT) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end else begin
                            err_count_d = err_count_q;
                        end
                        if (!first_fail_q) begin
                            first_fail_d = 1'b1;
                            fail_a_d     = bus.a;
                            fail_b_d     = bus.b;
                            fail_cin_d   = bus.cin;
                            fail_sum_d   = bus.sum;
                            fail_cout_d  = bus.cout;
                        end else begin
                            first_fail_d = first_fail_q;
                        end
                    end else begin
                        err_count_d = err_count_q;
                    end
                    if (vec_count_d == VEC_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (err_count_d == {ERR_W{1'b0}});
    end

    // State and registered outputs; reset abandons any partial run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            vec_count_q  <= {CNT_W{1'b0}};
            err_count_q  <= {ERR_W{1'b0}};
            first_fail_q <= 1'b0;
            fail_a_q     <= {WIDTH{1'b0}};
            fail_b_q     <= {WIDTH{1'b0}};
            fail_cin_q   <= 1'b0;
            fail_sum_q   <= {WIDTH{1'b0}};
            fail_cout_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_count_q  <= vec_count_d;
            err_count_q  <= err_count_d;
            first_fail_q <= first_fail_d;
            fail_a_q     <= fail_a_d;
            fail_b_q     <= fail_b_d;
            fail_cin_q   <= fail_cin_d;
            fail_sum_q   <= fail_sum_d;
            fail_cout_q  <= fail_cout_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign vec_count = vec_count_q;
    assign err_count = err_count_q;
    assign fail_a    = fail_a_q;
    assign fail_b    = fail_b_q;
    assign fail_cin  = fail_cin_q;
    assign fail_sum  = fail_sum_q;
    assign fail_cout = fail_cout_q;

endmodule

// File: tb/tb_adder_result_checker.sv
// Bench for adder_result_checker: three instances (full run, short saturating run,
// single-vector run) driven in lockstep and compared against an integer model.
module tb_adder_result_checker;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    adder_result_checker_if #(.WIDTH(8)) ifc0 ();
    adder_result_checker_if #(.WIDTH(8)) ifc1 ();
    adder_result_checker_if #(.WIDTH(8)) ifc2 ();

    logic        busy0, done0, pass0, fc0, fo0;
    logic        busy1, done1, pass1, fc1, fo1;
    logic        busy2, done2, pass2, fc2, fo2;
    logic [16:0] vec0, vec1, vec2;
    logic [15:0] err0, err2;
    logic [3:0]  err1;
    logic [7:0]  fa0, fb0, fs0, fa1, fb1, fs1, fa2, fb2, fs2;

    adder_result_checker #(.WIDTH(8)) dut0 (
        .clk(clk), .rst(rst), .bus(ifc0), .busy(busy0), .done(done0), .pass(pass0),
        .vec_count(vec0), .err_count(err0), .fail_a(fa0), .fail_b(fb0),
        .fail_cin(fc0), .fail_sum(fs0), .fail_cout(fo0));

    adder_result_checker #(.WIDTH(8), .N_VECTORS(20), .ERR_W(4)) dut1 (
        .clk(clk), .rst(rst), .bus(ifc1), .busy(busy1), .done(done1), .pass(pass1),
        .vec_count(vec1), .err_count(err1), .fail_a(fa1), .fail_b(fb1),
        .fail_cin(fc1), .fail_sum(fs1), .fail_cout(fo1));

    adder_result_checker #(.WIDTH(8), .N_VECTORS(1)) dut2 (
        .clk(clk), .rst(rst), .bus(ifc2), .busy(busy2), .done(done2), .pass(pass2),
        .vec_count(vec2), .err_count(err2), .fail_a(fa2), .fail_b(fb2),
        .fail_cin(fc2), .fail_sum(fs2), .fail_cout(fo2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 running, 2 finished.
    typedef struct {
        int phase;
        int vec;
        int err;
        int ff;
        int fa, fb, fc, fs, fo;
    } mdl_t;

    mdl_t m0, m1, m2;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m = '{default: 0};
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int st, int vld, int a, int b, int c,
                                      int s, int co, int nvec, int emax);
        mdl_t r;
        r = m;
        if (m.phase != 1 && st != 0) begin
            r = mdl_reset();
            r.phase = 1;
        end else if (m.phase == 1 && vld != 0) begin
            r.vec = m.vec + 1;
            if (a + b + c != s + 256 * co) begin
                if (m.err < emax) r.err = m.err + 1;
                if (m.ff == 0) begin
                    r.ff = 1; r.fa = a; r.fb = b; r.fc = c; r.fs = s; r.fo = co;
                end
            end
            if (r.vec == nvec) r.phase = 2;
        end
        return r;
    endfunction

    function automatic logic [8:0] good(input logic [7:0] a, input logic [7:0] b, input logic c);
        return 9'(a) + 9'(b) + 9'(c);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_all(input string tag, input mdl_t m, input logic bsy, input logic dn,
                           input logic ps, input logic [31:0] vc, input logic [31:0] ec,
                           input logic [7:0] fa, input logic [7:0] fb, input logic fc,
                           input logic [7:0] fs, input logic fo);
        chk({tag, "_busy"}, 32'(bsy), 32'(m.phase == 1));
        chk({tag, "_done"}, 32'(dn), 32'(m.phase == 2));
        chk({tag, "_pass"}, 32'(ps), 32'(m.phase == 2 && m.err == 0));
        chk({tag, "_vec"}, vc, 32'(m.vec));
        chk({tag, "_err"}, ec, 32'(m.err));
        chk({tag, "_fa"}, 32'(fa), 32'(m.fa));
        chk({tag, "_fb"}, 32'(fb), 32'(m.fb));
        chk({tag, "_fc"}, 32'(fc), 32'(m.fc));
        chk({tag, "_fs"}, 32'(fs), 32'(m.fs));
        chk({tag, "_fo"}, 32'(fo), 32'(m.fo));
    endtask

    task automatic c0(input string tag);
        cmp_all(tag, m0, busy0, done0, pass0, 32'(vec0), 32'(err0), fa0, fb0, fc0, fs0, fo0);
    endtask
    task automatic c1(input string tag);
        cmp_all(tag, m1, busy1, done1, pass1, 32'(vec1), 32'(err1), fa1, fb1, fc1, fs1, fo1);
    endtask
    task automatic c2(input string tag);
        cmp_all(tag, m2, busy2, done2, pass2, 32'(vec2), 32'(err2), fa2, fb2, fc2, fs2, fo2);
    endtask

    task automatic v0(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [8:0] r);
        ifc0.a = a; ifc0.b = b; ifc0.cin = c; ifc0.sum = r[7:0]; ifc0.cout = r[8];
    endtask
    task automatic v1(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [8:0] r);
        ifc1.a = a; ifc1.b = b; ifc1.cin = c; ifc1.sum = r[7:0]; ifc1.cout = r[8];
    endtask
    task automatic v2(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [8:0] r);
        ifc2.a = a; ifc2.b = b; ifc2.cin = c; ifc2.sum = r[7:0]; ifc2.cout = r[8];
    endtask

    // Advance one clock: model consumes what the DUTs will sample, then settle.
    task automatic tick();
        m0 = mdl_step(m0, ifc0.start, ifc0.in_valid, ifc0.a, ifc0.b, ifc0.cin, ifc0.sum, ifc0.cout, 65536, 65535);
        m1 = mdl_step(m1, ifc1.start, ifc1.in_valid, ifc1.a, ifc1.b, ifc1.cin, ifc1.sum, ifc1.cout, 20, 15);
        m2 = mdl_step(m2, ifc2.start, ifc2.in_valid, ifc2.a, ifc2.b, ifc2.cin, ifc2.sum, ifc2.cout, 1, 65535);
        @(posedge clk);
        #1;
    endtask

    task automatic rnd0(input int n, input int corrupt);
        logic [7:0] a, b;
        logic       c;
        logic [8:0] r;
        for (int k = 0; k < n; k++) begin
            a = 8'($urandom_range(255, 0));
            b = 8'($urandom_range(255, 0));
            c = 1'($urandom_range(1, 0));
            r = good(a, b, c);
            if (corrupt != 0 && $urandom_range(7, 0) == 0) r = r ^ 9'($urandom_range(510, 0) + 1);
            v0(a, b, c, r);
            ifc0.in_valid = 1'b1;
            tick();
        end
        ifc0.in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] a, b, first_a, first_b;
        logic       c, first_c;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        {ifc0.start, ifc0.in_valid, ifc0.a, ifc0.b, ifc0.cin, ifc0.sum, ifc0.cout} = '0;
        {ifc1.start, ifc1.in_valid, ifc1.a, ifc1.b, ifc1.cin, ifc1.sum, ifc1.cout} = '0;
        {ifc2.start, ifc2.in_valid, ifc2.a, ifc2.b, ifc2.cin, ifc2.sum, ifc2.cout} = '0;
        m0 = mdl_reset(); m1 = mdl_reset(); m2 = mdl_reset();
        #7;
        c0("rst0"); c1("rst1"); c2("rst2");
        rst = 1'b0;
        tick();

        // Exhaustive sweep with a correct adder, cin=0.
        ifc0.start = 1'b1; ifc0.in_valid = 1'b1;
        tick();
        ifc0.start = 1'b0;
        c0("sweep_start");
        for (int i = 0; i < 65536; i++) begin
            a = 8'(i >> 8);
            b = 8'(i);
            v0(a, b, 1'b0, good(a, b, 1'b0));
            tick();
            if (i % 8192 == 8191 || i == 65534) c0("sweep_mid");
        end
        ifc0.in_valid = 1'b0;
        c0("sweep_end");
        chk("sweep_vec", 32'(vec0), 32'd65536);
        chk("sweep_pass", 32'(pass0), 32'd1);

        // Restart from DONE, then a single faulty vector among good ones.
        ifc0.start = 1'b1;
        tick();
        ifc0.start = 1'b0;
        c0("restart");
        rnd0(10, 0);
        v0(8'h0F, 8'h01, 1'b0, 9'h011);
        ifc0.in_valid = 1'b1;
        tick();
        rnd0(5, 0);
        c0("fault");
        chk("fault_fa", 32'(fa0), 32'h0F);
        chk("fault_fs", 32'(fs0), 32'h11);

        // Carry-out boundary vectors.
        ifc0.in_valid = 1'b1;
        v0(8'hFF, 8'h01, 1'b0, 9'h100);
        tick();
        c0("carry_ok");
        chk("carry_ok_err", 32'(err0), 32'd1);
        v0(8'hFF, 8'h01, 1'b0, 9'h000);
        tick();
        chk("carry_bad_err", 32'(err0), 32'd2);
        v0(8'hFF, 8'hFF, 1'b1, 9'h1FF);
        tick();
        c0("carry_max");
        chk("carry_max_err", 32'(err0), 32'd2);
        ifc0.in_valid = 1'b0;

        // Random vectors with sporadic corruption, with bubbles.
        rnd0(100, 1);
        tick();
        rnd0(100, 1);
        c0("random");

        // Reset mid-run, then valid without start is ignored.
        rst = 1'b1;
        m0 = mdl_reset(); m1 = mdl_reset(); m2 = mdl_reset();
        #1;
        c0("midrst");
        rst = 1'b0;
        rnd0(5, 0);
        c0("nostart");

        // Start with in_valid high, then valid toggling.
        ifc0.start = 1'b1; ifc0.in_valid = 1'b1;
        tick();
        ifc0.start = 1'b0;
        c0("startprio");
        chk("startprio_vec", 32'(vec0), 32'd0);
        for (int k = 0; k < 10; k++) begin
            a = 8'($urandom_range(255, 0));
            v0(a, 8'h5A, 1'b1, good(a, 8'h5A, 1'b1));
            ifc0.in_valid = (k % 2 == 0);
            tick();
        end
        ifc0.in_valid = 1'b0;
        c0("toggle");
        chk("toggle_vec", 32'(vec0), 32'd5);

        // Short run: every vector wrong, counter saturates.
        ifc1.start = 1'b1;
        tick();
        ifc1.start = 1'b0;
        ifc1.in_valid = 1'b1;
        first_a = 8'h00; first_b = 8'h00; first_c = 1'b0;
        for (int k = 0; k < 20; k++) begin
            a = 8'($urandom_range(255, 0));
            b = 8'($urandom_range(255, 0));
            c = 1'($urandom_range(1, 0));
            if (k == 0) begin first_a = a; first_b = b; first_c = c; end
            v1(a, b, c, good(a, b, c) + 9'd1);
            tick();
            if (k == 18) c1("sat_pre");
        end
        c1("sat_done");
        chk("sat_err", 32'(err1), 32'hF);
        chk("sat_fa", 32'(fa1), 32'(first_a));
        chk("sat_fb", 32'(fb1), 32'(first_b));
        chk("sat_fc", 32'(fc1), 32'(first_c));
        tick();
        tick();
        c1("done_hold");
        chk("done_vec", 32'(vec1), 32'd20);

        // Restart from DONE with in_valid high; good vectors with gaps.
        ifc1.start = 1'b1;
        tick();
        ifc1.start = 1'b0;
        c1("rerun");
        for (int k = 0; k < 40; k++) begin
            a = 8'($urandom_range(255, 0));
            b = 8'($urandom_range(255, 0));
            v1(a, b, 1'b1, good(a, b, 1'b1));
            ifc1.in_valid = (k % 2 == 1);
            tick();
        end
        ifc1.in_valid = 1'b0;
        c1("rerun_done");
        chk("rerun_pass", 32'(pass1), 32'd1);

        // Single-vector runs.
        ifc2.start = 1'b1;
        tick();
        ifc2.start = 1'b0;
        ifc2.in_valid = 1'b1;
        v2(8'hFF, 8'hFF, 1'b1, 9'h1FF);
        tick();
        c2("one_good");
        ifc2.start = 1'b1;
        tick();
        ifc2.start = 1'b0;
        v2(8'h80, 8'h80, 1'b0, 9'h000);
        tick();
        ifc2.in_valid = 1'b0;
        c2("one_bad");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
